// File: rtl/fixed_point_div.sv
// fixed_point_div: sequential signed fixed-point divider (radix-2 restoring, one quotient bit per cycle).
// Define FIXED_DIV_SATURATE_EN to clamp overflow and divide-by-zero results instead of wrapping.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

package fixed_point;
  typedef logic [`FIXED_W-1:0] fixed_point_t;
endpackage

module fixed_point_div
  import fixed_point::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  fixed_point_t op1,
  input  fixed_point_t op2,
  output logic         out_valid,
  input  logic         out_ready,
  output fixed_point_t result,
  output logic         overflow,
  output logic         div_by_zero
);
  localparam int W = `FIXED_W;
  localparam int F = `FIXED_FRACTION_W;
  localparam int N = W + F;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N = CW'(N);
  localparam logic [CW-1:0] CNT_1 = CW'(1);
  localparam logic [W-1:0] MAX_P = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_N = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state;
  logic sign, ge, q_ovf, zero_div;
  logic [W-1:0] dvs, mag1, mag2;
  logic [N-1:0] dvd, quo;
  logic [W:0] rem, trial, diff;
  logic [CW-1:0] cnt;
  fixed_point_t q_wrap, fix_res, dbz_res;
  always_comb begin
    mag1 = op1[W-1] ? -op1 : op1;
    mag2 = op2[W-1] ? -op2 : op2;
    zero_div = op2 == '0;
    trial = {rem[W-1:0], dvd[N-1]};
    diff = trial - {1'b0, dvs};
    ge = trial >= {1'b0, dvs};
    // negative results may reach one step further: -2^(W-1) is representable
    q_ovf = sign ? (quo > N'(MAX_N)) : (quo > N'(MAX_P));
    q_wrap = sign ? -quo[W-1:0] : quo[W-1:0];
`ifdef FIXED_DIV_SATURATE_EN
    fix_res = q_ovf ? (sign ? MAX_N : MAX_P) : q_wrap;
    dbz_res = op1[W-1] ? MAX_N : MAX_P;
`else
    fix_res = q_wrap;
    dbz_res = '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      div_by_zero <= 1'b0;
      sign <= 1'b0;
      dvs <= '0;
      dvd <= '0;
      quo <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          sign <= op1[W-1] ^ op2[W-1];
          dvs <= mag2;
          dvd <= {mag1, {F{1'b0}}};
          rem <= '0;
          quo <= '0;
          cnt <= CNT_N;
          div_by_zero <= zero_div;
          overflow <= zero_div;
          result <= zero_div ? dbz_res : '0;
          out_valid <= zero_div;
          state <= zero_div ? DONE : BUSY;
        end
        BUSY: begin
          rem <= ge ? diff : trial;
          quo <= {quo[N-2:0], ge};
          dvd <= dvd << 1;
          cnt <= cnt - CNT_1;
          if (cnt == CNT_1) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          overflow <= q_ovf;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
